// File: rtl/clic_ip_writer_if.sv
// clic_ip_writer_if
// Claim handshake between the CLIC arbiter/core side and clic_ip_writer.
//   claim_valid_i : claim request (arbiter -> writer)
//   claim_id_i    : claimed source id (arbiter -> writer)
//   claim_ready_o : writer can accept a claim this cycle
//   claim_ack_o   : one-cycle pulse, the claim has been processed
//   claim_hit_o   : valid with claim_ack_o; claimed source was edge-mode and pending
// Modports: master = arbiter/core side, slave = clic_ip_writer.
interface clic_ip_writer_if #(
  parameter int N_SOURCE = 32
);
  localparam int IdWidth = $clog2(N_SOURCE);

  logic               claim_valid_i;
  logic [IdWidth-1:0] claim_id_i;
  logic               claim_ready_o;
  logic               claim_ack_o;
  logic               claim_hit_o;

  modport master (
    output claim_valid_i,
    output claim_id_i,
    input  claim_ready_o,
    input  claim_ack_o,
    input  claim_hit_o
  );

  modport slave (
    input  claim_valid_i,
    input  claim_id_i,
    output claim_ready_o,
    output claim_ack_o,
    output claim_hit_o
  );
endinterface

// File: rtl/clic_ip_writer.sv
// clic_ip_writer
// Hardware side of the clicint pending-bit field. Synchronizes (optionally) the
// raw interrupt lines, decodes level/edge triggers of either polarity, holds the
// authoritative pending state and drives the hw2reg ip.d/ip.de writes. Claims
// from the arbiter clear edge-triggered pending bits.
//
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   intsrc_i       : raw interrupt lines
//   le_i, pol_i    : per-source trigger mode (1 = edge) and polarity (1 = low/falling)
//   ip_reg_q_i     : current register value of clicint.ip.q
//   sw_we_i/sw_wd_i: software write strobe/data for the ip field
//   claim_if       : claim handshake (slave modport)
//   ip_o           : pending vector to the adapter/arbiter
//   ip_d_o/ip_de_o : hw2reg write data/enable for the ip field
//
// Build option: define CLIC_IP_SYNC_EN to insert a 2-flop synchronizer on every
// intsrc_i bit. Without it the sources must be synchronous to clk_i.
module clic_ip_writer #(
  parameter int N_SOURCE = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_SOURCE-1:0] intsrc_i,
  input  logic [N_SOURCE-1:0] le_i,
  input  logic [N_SOURCE-1:0] pol_i,
  input  logic [N_SOURCE-1:0] ip_reg_q_i,
  input  logic [N_SOURCE-1:0] sw_we_i,
  input  logic [N_SOURCE-1:0] sw_wd_i,
  clic_ip_writer_if.slave     claim_if,
  output logic [N_SOURCE-1:0] ip_o,
  output logic [N_SOURCE-1:0] ip_d_o,
  output logic [N_SOURCE-1:0] ip_de_o
);

  localparam int IdWidth = $clog2(N_SOURCE);

  typedef enum logic {
    IDLE,
    ACK
  } claim_state_e;

  claim_state_e        state_q;
  logic [N_SOURCE-1:0] s;
  logic [N_SOURCE-1:0] prev_q;
  logic [N_SOURCE-1:0] pend_q;
  logic [N_SOURCE-1:0] pend_d;
  logic [N_SOURCE-1:0] act_edge;
  logic [N_SOURCE-1:0] claim_sel;
  logic [N_SOURCE-1:0] claim_clr;
  logic                claim_accept;
  logic                claim_hit_d;

`ifdef CLIC_IP_SYNC_EN
  logic [N_SOURCE-1:0] sync1_q;
  logic [N_SOURCE-1:0] sync2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= intsrc_i;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = intsrc_i;
`endif

  // Active edge: level changed and the new level is the asserted one.
  assign act_edge = (s ^ prev_q) & (s ^ pol_i);

  // One-hot decode of the claim id; out-of-range ids match no source.
  always_comb begin
    claim_sel = '0;
    for (int i = 0; i < N_SOURCE; i++) begin
      claim_sel[i] = (claim_if.claim_id_i == IdWidth'(i));
    end
  end

  assign claim_accept = claim_if.claim_valid_i & claim_if.claim_ready_o;
  assign claim_clr    = claim_accept ? claim_sel : '0;
  assign claim_hit_d  = |(claim_sel & le_i & pend_q);

  // Edge priority: edge > software write > claim clear, so no edge is lost.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < N_SOURCE; i++) begin
      if (!le_i[i]) begin
        pend_d[i] = s[i] ^ pol_i[i];
      end else if (act_edge[i]) begin
        pend_d[i] = 1'b1;
      end else if (sw_we_i[i]) begin
        pend_d[i] = sw_wd_i[i];
      end else if (claim_clr[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= '0;
      pend_q <= '0;
    end else begin
      prev_q <= s;
      pend_q <= pend_d;
    end
  end

  // Two-state claim FSM; ack and hit are registered so they align with ACK.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q                <= IDLE;
      claim_if.claim_ready_o <= 1'b1;
      claim_if.claim_ack_o   <= 1'b0;
      claim_if.claim_hit_o   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          claim_if.claim_ack_o <= 1'b0;
          claim_if.claim_hit_o <= 1'b0;
          if (claim_accept) begin
            state_q                <= ACK;
            claim_if.claim_ready_o <= 1'b0;
            claim_if.claim_ack_o   <= 1'b1;
            claim_if.claim_hit_o   <= claim_hit_d;
          end
        end
        ACK: begin
          state_q                <= IDLE;
          claim_if.claim_ready_o <= 1'b1;
          claim_if.claim_ack_o   <= 1'b0;
          claim_if.claim_hit_o   <= 1'b0;
        end
        default: begin
          state_q                <= IDLE;
          claim_if.claim_ready_o <= 1'b1;
          claim_if.claim_ack_o   <= 1'b0;
          claim_if.claim_hit_o   <= 1'b0;
        end
      endcase
    end
  end

  assign ip_o    = pend_q;
  assign ip_d_o  = pend_q;
  assign ip_de_o = pend_q ^ ip_reg_q_i;

endmodule

// File: tb/tb_clic_ip_writer.sv
// Directed testbench for clic_ip_writer. Uses 24 sources so that ids at and
// above N_SOURCE are representable in the 5-bit claim id.
module tb_clic_ip_writer;

  localparam int N = 24;
`ifdef CLIC_IP_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam logic [N-1:0] REG_RST = 24'h0F_0000;

  logic         clk;
  logic         rst;
  logic [N-1:0] intsrc;
  logic [N-1:0] le;
  logic [N-1:0] pol;
  logic [N-1:0] ip_reg;
  logic [N-1:0] sw_we;
  logic [N-1:0] sw_wd;
  logic [N-1:0] ip;
  logic [N-1:0] ip_d;
  logic [N-1:0] ip_de;

  int checks = 0;
  int errors = 0;
  logic hit_q[$];

  clic_ip_writer_if #(.N_SOURCE(N)) claim_if ();

  clic_ip_writer #(.N_SOURCE(N)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .intsrc_i   (intsrc),
    .le_i       (le),
    .pol_i      (pol),
    .ip_reg_q_i (ip_reg),
    .sw_we_i    (sw_we),
    .sw_wd_i    (sw_wd),
    .claim_if   (claim_if),
    .ip_o       (ip),
    .ip_d_o     (ip_d),
    .ip_de_o    (ip_de)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model of clicint.ip: software wins, otherwise hw2reg de/d.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ip_reg <= REG_RST;
    else     ip_reg <= (sw_we & sw_wd) | (~sw_we & ip_de & ip_d) | (~sw_we & ~ip_de & ip_reg);
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic val);
    intsrc[idx] = val;
  endtask

  task automatic popHit();
    logic exp;
    if (hit_q.size() == 0) begin
      checkOutput("claim_hit_queue_empty", 64'd0, 64'd1);
    end else begin
      exp = hit_q.pop_front();
      checkOutput("claim_hit", claim_if.claim_hit_o, exp);
    end
  endtask

  // Issues one claim and returns on the negedge where the ack is visible.
  task automatic doClaim(input logic [4:0] id, input logic exp_hit);
    bit seen;
    checkOutput("claim_ready_idle", claim_if.claim_ready_o, 1);
    claim_if.claim_valid_i = 1'b1;
    claim_if.claim_id_i    = id;
    hit_q.push_back(exp_hit);
    seen = 0;
    for (int w = 1; w <= 4 && !seen; w++) begin
      tick();
      if (claim_if.claim_ack_o === 1'b1) begin
        seen = 1;
        claim_if.claim_valid_i = 1'b0;
        checkOutput("claim_ack_latency", w, 1);
        popHit();
      end
    end
    if (!seen) begin
      checkOutput("claim_ack_timeout", 0, 1);
      claim_if.claim_valid_i = 1'b0;
      hit_q.delete();
    end
  endtask

  initial begin
    logic [4:0] ids [3];
    ids[0] = 5'd24;
    ids[1] = 5'd7;
    ids[2] = 5'd5;

    rst    = 1'b1;
    intsrc = '0;
    le     = '0;
    pol    = '0;
    sw_we  = '0;
    sw_wd  = '0;
    le[5]  = 1'b1;
    pol[5] = 1'b1;
    le[7]  = 1'b1;
    le[2]  = 1'b1;
    claim_if.claim_valid_i = 1'b0;
    claim_if.claim_id_i    = '0;

    // Reset state
    tick();
    tick();
    checkOutput("rst_ready", claim_if.claim_ready_o, 1);
    checkOutput("rst_ack", claim_if.claim_ack_o, 0);
    checkOutput("rst_hit", claim_if.claim_hit_o, 0);
    checkOutput("rst_ip", ip, 0);
    checkOutput("rst_ip_d", ip_d, 0);
    checkOutput("rst_ip_de", ip_de, REG_RST);
    rst = 1'b0;
    tick();
    tick();
    checkOutput("post_rst_ip", ip, 0);
    checkOutput("post_rst_ip_de", ip_de, 0);

    // Source 3, level high
    applyStimulus(3, 1'b1);
    repeat (LAT - 1) tick();
    checkOutput("lvl3_rise_early", ip[3], 0);
    tick();
    checkOutput("lvl3_rise", ip[3], 1);
    checkOutput("lvl3_de_pulse", ip_de[3], 1);
    tick();
    checkOutput("lvl3_de_drop", ip_de[3], 0);
    checkOutput("lvl3_hold", ip[3], 1);
    applyStimulus(3, 1'b0);
    repeat (LAT - 1) tick();
    checkOutput("lvl3_fall_early", ip[3], 1);
    tick();
    checkOutput("lvl3_fall", ip[3], 0);
    applyStimulus(3, 1'b1);
    repeat (LAT + 1) tick();
    doClaim(5'd3, 1'b0);
    checkOutput("lvl3_claim_ip", ip[3], 1);
    tick();
    applyStimulus(3, 1'b0);
    repeat (LAT) tick();
    checkOutput("lvl3_follow", ip[3], 0);

    // Source 5, edge, falling
    applyStimulus(5, 1'b1);
    repeat (LAT + 2) tick();
    checkOutput("edg5_rise_ignored", ip[5], 0);
    applyStimulus(5, 1'b0);
    repeat (LAT) tick();
    checkOutput("edg5_fall_set", ip[5], 1);
    repeat (3) tick();
    checkOutput("edg5_held", ip[5], 1);
    doClaim(5'd5, 1'b1);
    checkOutput("edg5_claim_clear", ip[5], 0);
    tick();

    // Source 7, edge coinciding with claim
    applyStimulus(7, 1'b1);
    repeat (LAT) tick();
    checkOutput("edg7_set", ip[7], 1);
    applyStimulus(7, 1'b0);
    repeat (LAT + 1) tick();
    checkOutput("edg7_fall_hold", ip[7], 1);
    applyStimulus(7, 1'b1);
    repeat (LAT - 1) tick();
    doClaim(5'd7, 1'b1);
    checkOutput("edg7_edge_wins", ip[7], 1);
    tick();

    // Source 2, software writes
    sw_we[2] = 1'b1;
    sw_wd[2] = 1'b1;
    tick();
    sw_we = '0;
    sw_wd = '0;
    checkOutput("sw2_write1", ip[2], 1);
    checkOutput("sw2_write1_de", ip_de[2], 0);
    sw_we[2] = 1'b1;
    tick();
    sw_we = '0;
    checkOutput("sw2_write0", ip[2], 0);
    applyStimulus(2, 1'b1);
    repeat (LAT - 1) tick();
    sw_we[2] = 1'b1;
    tick();
    sw_we = '0;
    checkOutput("sw2_edge_beats_w0", ip[2], 1);
    checkOutput("sw2_edge_de", ip_de[2], 1);
    checkOutput("sw2_ip_d", ip_d[2], 1);
    tick();
    checkOutput("sw2_de_drop", ip_de[2], 0);
    sw_we[2] = 1'b1;
    tick();
    sw_we = '0;
    checkOutput("sw2_clear_again", ip[2], 0);
    // Software write 1 together with a claim
    sw_we[2] = 1'b1;
    sw_wd[2] = 1'b1;
    claim_if.claim_valid_i = 1'b1;
    claim_if.claim_id_i    = 5'd2;
    hit_q.push_back(1'b0);
    tick();
    sw_we = '0;
    sw_wd = '0;
    claim_if.claim_valid_i = 1'b0;
    checkOutput("sw2_claim_ack", claim_if.claim_ack_o, 1);
    popHit();
    checkOutput("sw2_w1_beats_claim", ip[2], 1);
    tick();

    // Back-to-back claims with valid held high
    checkOutput("b2b_ip_before", ip, 24'h84);
    claim_if.claim_valid_i = 1'b1;
    claim_if.claim_id_i    = ids[0];
    hit_q.push_back(1'b0);
    hit_q.push_back(1'b1);
    hit_q.push_back(1'b0);
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k % 2 == 0) begin
        checkOutput("b2b_ack", claim_if.claim_ack_o, 1);
        checkOutput("b2b_ready_low", claim_if.claim_ready_o, 0);
        popHit();
        if (k == 0) checkOutput("b2b_oob_no_change", ip, 24'h84);
        if (k < 4) claim_if.claim_id_i = ids[k / 2 + 1];
        else       claim_if.claim_valid_i = 1'b0;
      end else begin
        checkOutput("b2b_no_ack", claim_if.claim_ack_o, 0);
        checkOutput("b2b_ready_high", claim_if.claim_ready_o, 1);
      end
    end
    checkOutput("b2b_ip_after", ip, 24'h04);

    // Reset asserted during ACK
    doClaim(5'd2, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_ack", claim_if.claim_ack_o, 0);
    checkOutput("rst_mid_ready", claim_if.claim_ready_o, 1);
    checkOutput("rst_mid_hit", claim_if.claim_hit_o, 0);
    checkOutput("rst_mid_ip", ip, 0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    checkOutput("rst_abort_no_ack", claim_if.claim_ack_o, 0);
    checkOutput("rst_abort_ready", claim_if.claim_ready_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
